fft_r4_16p_reorder: RTL and testbench
=====================================

// Module: fft_r4_16p_reorder
// PURPOSE
//  Output reorder buffer directly downstream of the 16-point radix-4 FFT core. Takes the core's
//  4-lane second-butterfly output (digit-reversed, 4 bins per group, 4 groups per frame).
//  Delivers the 16 bins serially in natural order 0..15 with a valid/ready handshake.
//  Ping-pong storage lets one frame fill while the previous frame drains.
// PARAMETERS
//  DATA_W  32  width of each real/imag component (signed two's complement)
// PORTS
//  clk              in   1         rising-edge clock
//  reset            in   1         asynchronous, active-low reset
//  in_valid         in   1         group present on in_*_real/im
//  in_first         in   1         qualifies group 0 of a frame (with in_valid)
//  in_0..3_real     in   DATA_W    lane l real; group g lane l carries bin 4*l+g
//  in_0..3_im       in   DATA_W    lane l imaginary
//  in_ready         out  1         write bank free; group accepted when in_valid&&in_ready
//  out_valid        out  1         out_real/out_im/out_index hold a valid bin
//  out_ready        in   1         sink accepts bin
//  out_real/out_im  out  DATA_W    bin value
//  out_index        out  4         bin number k, 0..15
//  out_last         out  1         out_index==15 while out_valid
// BEHAVIOUR
//  Storage: 2 banks x 16 entries x (real,im); per-bank full flag; wr_bank, rd_bank, wr_grp[1:0], rd_idx[3:0].
//  Write FSM: WAIT_SYNC (reset state), FILL.
//   WAIT_SYNC: accept only in_valid&&in_first&&in_ready; write as grp 0, wr_grp<=1, go FILL.
//   FILL: accepted group written at (lane l, grp wr_grp) of wr_bank; wr_grp++.
//   Accept of grp 3: set full[wr_bank], toggle wr_bank, go WAIT_SYNC.
//   in_first accepted in FILL with wr_grp!=0: partial frame discarded, group written as grp 0, wr_grp<=1.
//   Upstream cannot stall: in_valid&&!in_ready is a drop; group ignored, partial frame discarded, go WAIT_SYNC.
//  in_ready = !full[wr_bank] (registered state only, no combinational path from out_ready).
//  Read: out_valid = full[rd_bank]; out bin k=rd_idx reads entry (lane k>>2, grp k&3), i.e. natural order.
//   Transfer on out_valid&&out_ready: rd_idx++; at rd_idx==15 clear full[rd_bank], toggle rd_bank, rd_idx<=0.
//   While out_valid&&!out_ready all outputs hold stable.
//  Latency: bin 0 valid in cycle after grp 3 accepted; frame drains in 16 cycles at out_ready=1.
//  Same-cycle last read and write: bank freed by last read raises in_ready next cycle, never same cycle.
//  Write and read never target same bank (full flag interlock).
//  No arithmetic; values pass bit-exact, sign preserved (-2^(DATA_W-1) included).
//  Reset: FSM WAIT_SYNC, all pointers/flags 0, storage 0; out_valid=0, out_real=out_im=0, out_index=0, out_last=0, in_ready=1.
//   Reset mid-frame/mid-drain discards all buffered data.
// CONFIGURATION
//  FFT_REORDER_DROP_CNT_EN defined: extra port drop_cnt out 16, counts dropped groups (in_valid&&!in_ready),
//   saturates at 16'hFFFF, reset 0. Undefined: port and counter absent; drop behaviour otherwise identical.
// STRUCTURE
//  Package fft_r4_pkg: N_POINTS=16, RADIX=4, N_GROUPS=4, DATA_W default, write FSM state enum,
//   function digit_rev4(k) returning {k[1:0],k[3:2]}.
//  Sub-module fft_reorder_bank: one 16-entry bank, 4-wide group write, 1-wide indexed read; instantiated twice.
// TESTING
//  1 Single frame: in_first, groups g=0..3, lane l real=4*l+g, im=-(4*l+g), out_ready=1 -> out 0..15
//    in order, im=-k, out_index=k, out_last only at 15, bin 0 valid cycle after group 3.
//  2 Three frames back-to-back (12 consecutive groups), out_ready=1 -> frames 1,2 drained intact;
//    frame 3 groups dropped while both banks full, write FSM resyncs on next in_first; drop_cnt=4 if EN.
//  3 out_ready random 50% during drain -> no bin lost/duplicated, outputs stable while stalled.
//  4 in_first reasserted at wr_grp=2 with new data -> output frame contains only restarted frame's data.
//  5 reset low mid-drain at rd_idx=7 -> out_valid=0, outputs 0, in_ready=1 next edge; fresh frame then correct.
//  6 real=-2^31, im=2^31-1 on all lanes -> passed bit-exact on all 16 bins.

Source files
------------

// File: rtl/fft_r4_pkg.sv
// Shared constants, write-FSM state type and digit-reversal helper
// for the 16-point radix-4 FFT output reorder path.
package fft_r4_pkg;

   localparam int N_POINTS = 16;
   localparam int RADIX    = 4;
   localparam int N_GROUPS = 4;
   localparam int DATA_W   = 32;

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      FILL      = 1'b1
   } wr_state_t;

   // Arrival slot {grp,lane} maps to natural bin {lane,grp}
   function automatic logic [3:0] digit_rev4(input logic [3:0] k);
      return {k[1:0], k[3:2]};
   endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One 16-entry complex bank: 4-wide group write at digit-reversed
// addresses, 1-wide natural-order indexed read.
module fft_reorder_bank
   import fft_r4_pkg::*;
#(
   parameter int DATA_W = fft_r4_pkg::DATA_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [1:0]                    wr_grp,
   input  logic [RADIX-1:0][DATA_W-1:0]  wr_real,
   input  logic [RADIX-1:0][DATA_W-1:0]  wr_im,
   input  logic [3:0]                    rd_idx,
   output logic [DATA_W-1:0]             rd_real,
   output logic [DATA_W-1:0]             rd_im
);

   logic [DATA_W-1:0] mem_re [N_POINTS];
   logic [DATA_W-1:0] mem_im [N_POINTS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_POINTS; i++) begin
            mem_re[i] <= '0;
            mem_im[i] <= '0;
         end
      end else if (wr_en) begin
         for (int l = 0; l < RADIX; l++) begin
            mem_re[digit_rev4({wr_grp, 2'(l)})] <= wr_real[l];
            mem_im[digit_rev4({wr_grp, 2'(l)})] <= wr_im[l];
         end
      end
   end

   assign rd_real = mem_re[rd_idx];
   assign rd_im   = mem_im[rd_idx];

endmodule

// File: rtl/fft_r4_16p_reorder.sv
// Ping-pong reorder buffer: digit-reversed 4-lane groups in, natural-order
// serial bins out. FFT_REORDER_DROP_CNT_EN adds a saturating drop counter.
module fft_r4_16p_reorder
   import fft_r4_pkg::*;
#(
   parameter int DATA_W = fft_r4_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_first,
   input  logic [DATA_W-1:0] in_0_real,
   input  logic [DATA_W-1:0] in_0_im,
   input  logic [DATA_W-1:0] in_1_real,
   input  logic [DATA_W-1:0] in_1_im,
   input  logic [DATA_W-1:0] in_2_real,
   input  logic [DATA_W-1:0] in_2_im,
   input  logic [DATA_W-1:0] in_3_real,
   input  logic [DATA_W-1:0] in_3_im,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_real,
   output logic [DATA_W-1:0] out_im,
   output logic [3:0]        out_index,
   output logic              out_last
`ifdef FFT_REORDER_DROP_CNT_EN
   ,
   output logic [15:0]       drop_cnt
`endif
);

   wr_state_t  state_q, state_d;
   logic       wr_bank_q, wr_bank_d;
   logic [1:0] wr_grp_q, wr_grp_d;
   logic [1:0] wr_addr_grp;
   logic       wr_en;
   logic       set_full;
   logic [1:0] full_q, full_d;
   logic       rd_bank_q;
   logic [3:0] rd_idx_q;
   logic       acc, drop;
   logic       rd_xfer, rd_done;

   logic [RADIX-1:0][DATA_W-1:0] grp_re, grp_im;
   logic [DATA_W-1:0]            b_re [2];
   logic [DATA_W-1:0]            b_im [2];

   assign grp_re = {in_3_real, in_2_real, in_1_real, in_0_real};
   assign grp_im = {in_3_im, in_2_im, in_1_im, in_0_im};

   assign in_ready = !full_q[wr_bank_q];
   assign acc      = in_valid && in_ready;
   assign drop     = in_valid && !in_ready;

   always_comb begin
      state_d     = state_q;
      wr_bank_d   = wr_bank_q;
      wr_grp_d    = wr_grp_q;
      wr_addr_grp = wr_grp_q;
      wr_en       = 1'b0;
      set_full    = 1'b0;
      unique case (state_q)
         WAIT_SYNC: begin
            if (acc && in_first) begin
               wr_en       = 1'b1;
               wr_addr_grp = 2'd0;
               wr_grp_d    = 2'd1;
               state_d     = FILL;
            end
         end
         FILL: begin
            if (drop) begin
               wr_grp_d = 2'd0;
               state_d  = WAIT_SYNC;
            end else if (acc) begin
               wr_en = 1'b1;
               if (in_first) begin
                  // Restart: stale groups get overwritten by the new frame
                  wr_addr_grp = 2'd0;
                  wr_grp_d    = 2'd1;
               end else if (wr_grp_q == 2'd3) begin
                  set_full  = 1'b1;
                  wr_bank_d = !wr_bank_q;
                  wr_grp_d  = 2'd0;
                  state_d   = WAIT_SYNC;
               end else begin
                  wr_grp_d = wr_grp_q + 2'd1;
               end
            end
         end
         default: state_d = WAIT_SYNC;
      endcase
   end

   assign rd_xfer = out_valid && out_ready;
   assign rd_done = rd_xfer && (rd_idx_q == 4'hF);

   // Set and clear always address different banks
   always_comb begin
      full_d = full_q;
      if (rd_done)
         full_d[rd_bank_q] = 1'b0;
      if (set_full)
         full_d[wr_bank_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= WAIT_SYNC;
         wr_bank_q <= 1'b0;
         wr_grp_q  <= 2'd0;
         full_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         wr_bank_q <= wr_bank_d;
         wr_grp_q  <= wr_grp_d;
         full_q    <= full_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_bank_q <= 1'b0;
         rd_idx_q  <= 4'd0;
      end else if (rd_xfer) begin
         rd_idx_q <= rd_idx_q + 4'd1;
         if (rd_done)
            rd_bank_q <= !rd_bank_q;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_reorder_bank #(
         .DATA_W (DATA_W)
      ) u_bank (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (wr_en && (wr_bank_q == 1'(b))),
         .wr_grp  (wr_addr_grp),
         .wr_real (grp_re),
         .wr_im   (grp_im),
         .rd_idx  (rd_idx_q),
         .rd_real (b_re[b]),
         .rd_im   (b_im[b])
      );
   end

   assign out_valid = full_q[rd_bank_q];
   assign out_real  = b_re[rd_bank_q];
   assign out_im    = b_im[rd_bank_q];
   assign out_index = rd_idx_q;
   assign out_last  = out_valid && (rd_idx_q == 4'hF);

`ifdef FFT_REORDER_DROP_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         drop_cnt <= 16'd0;
      else if (drop && (drop_cnt != 16'hFFFF))
         drop_cnt <= drop_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fft_r4_16p_reorder.sv
// Directed/random bench for fft_r4_16p_reorder against a bin-array
// reference: bin k travels as lane k>>2 of group k&3.
module tb_fft_r4_16p_reorder;

   localparam int W = 32;

   typedef logic [W-1:0] frame_t [16];
   typedef struct packed {
      logic [3:0]   idx;
      logic         last;
      logic [W-1:0] re;
      logic [W-1:0] im;
   } bin_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_first = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] in_re [4];
   logic [W-1:0] in_im [4];
   logic         in_ready, out_valid, out_last;
   logic [W-1:0] out_real, out_im;
   logic [3:0]   out_index;
`ifdef FFT_REORDER_DROP_CNT_EN
   logic [15:0]  drop_cnt;
`endif

   int    errors = 0;
   int    checks = 0;
   bin_t  rx [$];
   logic  stall_prev = 1'b0;
   logic [71:0] held = '0;

   always #5 clk = ~clk;

   fft_r4_16p_reorder #(.DATA_W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .in_0_real (in_re[0]),
      .in_0_im   (in_im[0]),
      .in_1_real (in_re[1]),
      .in_1_im   (in_im[1]),
      .in_2_real (in_re[2]),
      .in_2_im   (in_im[2]),
      .in_3_real (in_re[3]),
      .in_3_im   (in_im[3]),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_real  (out_real),
      .out_im    (out_im),
      .out_index (out_index),
      .out_last  (out_last)
`ifdef FFT_REORDER_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [71:0] got,
                      input logic [71:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Capture transfers; a stalled bin must be unchanged one cycle later
   always @(negedge clk) begin
      if (stall_prev)
         chk("stall_hold",
             {3'b0, out_valid, out_index, out_real, out_im}, held);
      if (reset && out_valid && out_ready)
         rx.push_back('{out_index, out_last, out_real, out_im});
      stall_prev <= reset && out_valid && !out_ready;
      held       <= {3'b0, out_valid, out_index, out_real, out_im};
   end

   task automatic send_group(input frame_t re, input frame_t im,
                             input int g, input logic first);
      in_valid = 1'b1;
      in_first = first;
      for (int l = 0; l < 4; l++) begin
         in_re[l] = re[4*l+g];
         in_im[l] = im[4*l+g];
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   task automatic send_frame(input frame_t re, input frame_t im);
      for (int g = 0; g < 4; g++)
         send_group(re, im, g, g == 0);
   endtask

   task automatic rand_frame(output frame_t re, output frame_t im);
      for (int k = 0; k < 16; k++) begin
         re[k] = W'($urandom);
         im[k] = W'($urandom);
      end
   endtask

   task automatic check_frame(input string tag, input frame_t re,
                              input frame_t im, input bit rnd,
                              output int n);
      bin_t got;
      bin_t exp;
      n = 0;
      while (rx.size() < 16 && n < 400) begin
         if (rnd)
            out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         n++;
      end
      out_ready = 1'b1;
      chk({tag, " count"}, 72'(rx.size()), 72'(16));
      for (int k = 0; k < 16; k++) begin
         got = (rx.size() > 0) ? rx.pop_front() : 'x;
         exp = '{4'(k), k == 15, re[k], im[k]};
         chk($sformatf("%s bin%0d", tag, k), 72'(got), 72'(exp));
      end
   endtask

   task automatic idle(input int c);
      repeat (c) @(posedge clk);
      #1;
   endtask

   frame_t fa_re, fa_im, fb_re, fb_im, fc_re, fc_im;
   int     n;

   initial begin
      for (int l = 0; l < 4; l++) begin
         in_re[l] = '0;
         in_im[l] = '0;
      end
      #2 reset = 1'b0;
      #1;
      chk("reset_state",
          72'({out_valid, out_last, out_index, in_ready, out_real, out_im}),
          72'({1'b0, 1'b0, 4'd0, 1'b1, 64'd0}));
      idle(2);
      reset = 1'b1;
      idle(1);

      // 1: single frame, ramp data, latency and drain length
      for (int k = 0; k < 16; k++) begin
         fa_re[k] = W'(k);
         fa_im[k] = W'(-k);
      end
      for (int g = 0; g < 3; g++)
         send_group(fa_re, fa_im, g, g == 0);
      chk("t1 not_valid_early", 72'(out_valid), 72'(0));
      send_group(fa_re, fa_im, 3, 1'b0);
      chk("t1 bin0_latency", 72'({out_valid, out_index, out_last}),
          72'({1'b1, 4'd0, 1'b0}));
      check_frame("t1", fa_re, fa_im, 1'b0, n);
      chk("t1 drain_cycles", 72'(n), 72'(16));
      chk("t1 idle_after", 72'({out_valid, in_ready}), 72'({1'b0, 1'b1}));

      // 2: three frames back-to-back, third dropped, then resync
      rand_frame(fa_re, fa_im);
      rand_frame(fb_re, fb_im);
      rand_frame(fc_re, fc_im);
      chk("t2 ready_a", 72'(in_ready), 72'(1));
      send_frame(fa_re, fa_im);
      chk("t2 ready_b", 72'(in_ready), 72'(1));
      send_frame(fb_re, fb_im);
      chk("t2 ready_c", 72'(in_ready), 72'(0));
      send_frame(fc_re, fc_im);
`ifdef FFT_REORDER_DROP_CNT_EN
      chk("t2 drop_cnt", 72'(drop_cnt), 72'(4));
`endif
      check_frame("t2a", fa_re, fa_im, 1'b0, n);
      check_frame("t2b", fb_re, fb_im, 1'b0, n);
      idle(20);
      chk("t2 no_frame_c", 72'({out_valid, 8'(rx.size())}), 72'(0));
      rand_frame(fa_re, fa_im);
      send_group(fc_re, fc_im, 1, 1'b0);
      send_group(fc_re, fc_im, 2, 1'b0);
      chk("t2 stray_ignored", 72'(out_valid), 72'(0));
      send_frame(fa_re, fa_im);
      check_frame("t2d", fa_re, fa_im, 1'b0, n);

      // 3: random backpressure over two frames
      rand_frame(fa_re, fa_im);
      rand_frame(fb_re, fb_im);
      send_frame(fa_re, fa_im);
      send_frame(fb_re, fb_im);
      check_frame("t3a", fa_re, fa_im, 1'b1, n);
      check_frame("t3b", fb_re, fb_im, 1'b1, n);
      idle(4);
      chk("t3 no_extra", 72'(rx.size()), 72'(0));

      // 4: in_first reasserted at group 2 restarts the frame
      rand_frame(fa_re, fa_im);
      rand_frame(fb_re, fb_im);
      send_group(fa_re, fa_im, 0, 1'b1);
      send_group(fa_re, fa_im, 1, 1'b0);
      send_frame(fb_re, fb_im);
      check_frame("t4", fb_re, fb_im, 1'b0, n);
      idle(4);
      chk("t4 no_extra", 72'({out_valid, 8'(rx.size())}), 72'(0));

      // 5: reset mid-drain at bin 7, then a fresh frame
      rand_frame(fa_re, fa_im);
      send_frame(fa_re, fa_im);
      n = 0;
      while (out_index != 4'd7 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t5 reached_bin7", 72'({out_valid, out_index}),
          72'({1'b1, 4'd7}));
      reset = 1'b0;
      #1;
      chk("t5 reset_outputs",
          72'({out_valid, out_last, out_index, in_ready, out_real, out_im}),
          72'({1'b0, 1'b0, 4'd0, 1'b1, 64'd0}));
      @(posedge clk);
      #1;
      chk("t5 reset_next_edge", 72'({out_valid, in_ready}),
          72'({1'b0, 1'b1}));
      reset = 1'b1;
      rx.delete();
      idle(1);
      rand_frame(fb_re, fb_im);
      send_frame(fb_re, fb_im);
      check_frame("t5", fb_re, fb_im, 1'b0, n);

      // 6: extreme signed values pass untouched
      for (int k = 0; k < 16; k++) begin
         fa_re[k] = 32'h8000_0000;
         fa_im[k] = 32'h7FFF_FFFF;
      end
      send_frame(fa_re, fa_im);
      check_frame("t6", fa_re, fa_im, 1'b0, n);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
